// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared types and defaults for the freq_meter period meter.
// The measurement FSM states, the default parameter values and the helper
// that sizes the period accumulator all live here so the top and any
// future users agree on them.
package freq_meter_pkg;

   // Measurement FSM states: idle, waiting for the first edge, measuring.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      MEAS = 2'd2
   } meter_state_e;

   // Default period counter width; the counter saturates at all-ones.
   localparam int DEF_CNT_W    = 12;
   // Default averaging window is 2^DEF_WIN_LOG2 periods.
   localparam int DEF_WIN_LOG2 = 2;
   // Default number of consecutive in-tolerance results needed for lock.
   localparam int DEF_LOCK_CNT = 4;

   // The accumulator holds up to 2^win_log2 saturated periods, so it needs
   // win_log2 extra bits above the counter width and can never overflow.
   function automatic int acc_width(input int cnt_w, input int win_log2);
      return cnt_w + win_log2;
   endfunction

endpackage

// File: rtl/freq_meter_edge_sync.sv
// edge_sync: brings the asynchronous divided clock into the clk domain
// through a 2-flop synchroniser, then produces a registered one-cycle pulse
// for each rising edge. The pulse appears 3 clk rising edges after the
// input rises; the input high and low times must each be at least 2 clk
// cycles so no edge is lost.
module edge_sync (
   input  logic clk,
   input  logic reset,
   input  logic d_in,
   output logic edge_pulse
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic prev_q,  prev_d;
   logic pulse_q, pulse_d;

   // Next-state for the synchroniser chain, the delayed copy used for edge
   // detection, and the registered rising-edge pulse.
   always_comb begin
      sync1_d = d_in;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      pulse_d = sync2_q & ~prev_q;
   end

   // All flops clear on the asynchronous active-low reset so a freshly reset
   // block never sees a phantom edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         pulse_q <= pulse_d;
      end
   end

   assign edge_pulse = pulse_q;

endmodule

// File: rtl/freq_meter.sv
// freq_meter: measures the period of a divided clock in clk cycles,
// averages it over 2^WIN_LOG2 periods and offers each average to the
// consumer on a valid/ready handshake. Optional frequency-lock detection
// is built when the macro FREQ_METER_LOCK_EN is defined; otherwise lock
// is tied low and target_period/lock_tol are ignored.
module freq_meter
   import freq_meter_pkg::*;
#(
   parameter int CNT_W    = DEF_CNT_W,
   parameter int WIN_LOG2 = DEF_WIN_LOG2,
   parameter int LOCK_CNT = DEF_LOCK_CNT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             div_in,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   input  logic             period_ready,
   output logic             period_sat,
   output logic             overrun,
   input  logic [CNT_W-1:0] target_period,
   input  logic [CNT_W-1:0] lock_tol,
   output logic             lock
);

   localparam int               ACC_W   = acc_width(CNT_W, WIN_LOG2);
   localparam int               N_W     = WIN_LOG2 + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [N_W-1:0]   N_LAST  = N_W'((1 << WIN_LOG2) - 1);

   meter_state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [N_W-1:0]   n_q, n_d;
   logic             sat_win_q, sat_win_d;

   logic [CNT_W-1:0] period_q, period_d;
   logic             period_valid_q, period_valid_d;
   logic             period_sat_q, period_sat_d;
   logic             overrun_q, overrun_d;

   logic             div_edge;
   logic             win_done;
   logic             xfer;
   logic             load;
   logic             going_idle;
   logic [ACC_W-1:0] acc_sum;
   logic [CNT_W-1:0] res_period;

   edge_sync u_edge_sync (
      .clk        (clk),
      .reset      (reset),
      .d_in       (div_in),
      .edge_pulse (div_edge)
   );

   // The window sum includes the period that the closing edge just ended;
   // the average is the truncated sum divided by the window length.
   always_comb begin
      acc_sum    = acc_q + ACC_W'(cnt_q);
      res_period = CNT_W'(acc_sum >> WIN_LOG2);
      going_idle = (state_q != IDLE) && !en;
   end

   // Measurement FSM: ARM throws away the first edge (it only starts the
   // count), MEAS counts clk cycles between edges and accumulates them.
   // A completed window restarts on the same edge so throughput is one
   // result per window with no gap; dropping en discards a partial window.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      n_d       = n_q;
      sat_win_d = sat_win_q;
      win_done  = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d     = '0;
            acc_d     = '0;
            n_d       = '0;
            sat_win_d = 1'b0;
            if (en) begin
               state_d = ARM;
            end
         end
         ARM: begin
            if (!en) begin
               state_d = IDLE;
            end else if (div_edge) begin
               cnt_d   = CNT_ONE;
               state_d = MEAS;
            end
         end
         MEAS: begin
            if (!en) begin
               state_d   = IDLE;
               cnt_d     = '0;
               acc_d     = '0;
               n_d       = '0;
               sat_win_d = 1'b0;
            end else if (div_edge) begin
               cnt_d = CNT_ONE;
               if (n_q == N_LAST) begin
                  win_done  = 1'b1;
                  acc_d     = '0;
                  n_d       = '0;
                  sat_win_d = 1'b0;
               end else begin
                  acc_d = acc_sum;
                  n_d   = n_q + 1'b1;
               end
            end else if (cnt_q == CNT_MAX) begin
               sat_win_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output handshake: a transfer empties the holding register and clears
   // overrun; a new result loads unless the old one is still waiting and
   // unaccepted, in which case the new one is dropped and overrun latches.
   always_comb begin
      period_d       = period_q;
      period_sat_d   = period_sat_q;
      period_valid_d = period_valid_q;
      overrun_d      = overrun_q;
      xfer           = period_valid_q && period_ready;
      load           = win_done && !(period_valid_q && !period_ready);
      if (xfer) begin
         period_valid_d = 1'b0;
         overrun_d      = 1'b0;
      end
      if (win_done && !load) begin
         overrun_d = 1'b1;
      end
      if (load) begin
         period_d       = res_period;
         period_sat_d   = sat_win_q;
         period_valid_d = 1'b1;
      end
   end

   // State, measurement and output registers, all cleared asynchronously;
   // a result pending at reset is simply lost.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         acc_q          <= '0;
         n_q            <= '0;
         sat_win_q      <= 1'b0;
         period_q       <= '0;
         period_valid_q <= 1'b0;
         period_sat_q   <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         acc_q          <= acc_d;
         n_q            <= n_d;
         sat_win_q      <= sat_win_d;
         period_q       <= period_d;
         period_valid_q <= period_valid_d;
         period_sat_q   <= period_sat_d;
         overrun_q      <= overrun_d;
      end
   end

   assign period       = period_q;
   assign period_valid = period_valid_q;
   assign period_sat   = period_sat_q;
   assign overrun      = overrun_q;

`ifdef FREQ_METER_LOCK_EN

   localparam int             GOOD_W   = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
   localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_CNT);

   logic [GOOD_W-1:0] good_q, good_d;
   logic              lock_q, lock_d;
   logic [CNT_W-1:0]  lock_diff;
   logic              in_tol;
   logic [GOOD_W-1:0] good_next;

   // Lock tracking is evaluated only on results that actually load into the
   // output register. A saturated window can never count as in tolerance.
   // Leaving measurement forgets any lock history.
   always_comb begin
      good_d    = good_q;
      lock_d    = lock_q;
      lock_diff = (res_period >= target_period) ? (res_period - target_period)
                                                : (target_period - res_period);
      in_tol    = !sat_win_q && (lock_diff <= lock_tol);
      good_next = (good_q == GOOD_MAX) ? good_q : (good_q + 1'b1);
      if (going_idle) begin
         good_d = '0;
         lock_d = 1'b0;
      end else if (load) begin
         if (in_tol) begin
            good_d = good_next;
            lock_d = (good_next == GOOD_MAX);
         end else begin
            good_d = '0;
            lock_d = 1'b0;
         end
      end
   end

   // Consecutive-good counter and lock flag registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         good_q <= '0;
         lock_q <= 1'b0;
      end else begin
         good_q <= good_d;
         lock_q <= lock_d;
      end
   end

   assign lock = lock_q;

`else

   logic unused_lock_inputs;

   // Without lock detection the target and tolerance inputs go nowhere.
   assign unused_lock_inputs = ^{target_period, lock_tol, going_idle};
   assign lock               = 1'b0;

`endif

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: scoreboard bench for freq_meter. Expected averages are
// computed from the div_in periods the bench generates and queued at the
// moment the window-closing edge is driven; a monitor pops and compares them
// when a result is transferred. A second instance with a 4-bit counter
// covers saturation. Lock expectations follow FREQ_METER_LOCK_EN.
module tb_freq_meter;

   localparam int WIN = 4;

   typedef struct packed {
      logic [11:0] period;
      logic        sat;
      logic        lock;
      int          gap;
   } sb_entry_t;

   logic        clk;
   logic        reset;
   logic        en;
   logic        divIn;
   logic [11:0] period;
   logic        periodValid;
   logic        periodReady;
   logic        periodSat;
   logic        overrun;
   logic [11:0] targetPeriod;
   logic [11:0] lockTol;
   logic        lock;

   logic        en2;
   logic [3:0]  period2;
   logic        periodValid2;
   logic        periodReady2;
   logic        periodSat2;
   logic        overrun2;
   logic        lock2;

   sb_entry_t   sbQ[$];
   int          stimPer[$];
   int          checks;
   int          errors;
   int          cycleCnt;
   int          lastXfer;
   int          goodCnt;

   freq_meter #(.CNT_W(12), .WIN_LOG2(2), .LOCK_CNT(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .en            (en),
      .div_in        (divIn),
      .period        (period),
      .period_valid  (periodValid),
      .period_ready  (periodReady),
      .period_sat    (periodSat),
      .overrun       (overrun),
      .target_period (targetPeriod),
      .lock_tol      (lockTol),
      .lock          (lock)
   );

   freq_meter #(.CNT_W(4), .WIN_LOG2(2), .LOCK_CNT(4)) dutSat (
      .clk           (clk),
      .reset         (reset),
      .en            (en2),
      .div_in        (divIn),
      .period        (period2),
      .period_valid  (periodValid2),
      .period_ready  (periodReady2),
      .period_sat    (periodSat2),
      .overrun       (overrun2),
      .target_period (4'd8),
      .lock_tol      (4'd1),
      .lock          (lock2)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Free-running cycle counter used to measure result spacing.
   always @(posedge clk) begin
      cycleCnt <= cycleCnt + 1;
   end

   // Hard time limit so a stuck run still ends with a FAIL line.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference lock model: consecutive in-tolerance results, saturating.
   task automatic updateLock(input int avg, output logic lk);
`ifdef FREQ_METER_LOCK_EN
      int diff;
      diff = (avg >= int'(targetPeriod)) ? avg - int'(targetPeriod) : int'(targetPeriod) - avg;
      if (diff <= int'(lockTol)) begin
         if (goodCnt < 4) goodCnt = goodCnt + 1;
      end else begin
         goodCnt = 0;
      end
      lk = (goodCnt == 4);
`else
      lk = 1'b0;
`endif
   endtask

   // One div_in period of p clk cycles, starting with a rising edge.
   task automatic genPeriod(input int p);
      divIn = 1'b1;
      repeat (p / 2) tick();
      divIn = 1'b0;
      repeat (p - p / 2) tick();
   endtask

   // Enables the main meter and plays stimPer; the first rise only arms.
   // Each window of WIN periods is queued as it closes, up to nPush results.
   task automatic applyStimulus(input int nPush);
      int        pushed;
      int        sum;
      bit        first;
      logic      lk;
      sb_entry_t e;
      en = 1'b1;
      repeat (3) tick();
      pushed = 0;
      first  = 1'b1;
      for (int i = 0; i < stimPer.size(); i++) begin
         if (i > 0 && (i % WIN) == 0 && pushed < nPush) begin
            sum = 0;
            for (int j = i - WIN; j < i; j++) sum = sum + stimPer[j];
            updateLock(sum >> 2, lk);
            e.period = 12'(sum >> 2);
            e.sat    = 1'b0;
            e.lock   = lk;
            e.gap    = first ? 0 : sum;
            first    = 1'b0;
            sbQ.push_back(e);
            pushed   = pushed + 1;
         end
         genPeriod(stimPer[i]);
      end
      repeat (4) tick();
   endtask

   task automatic endRun();
      en = 1'b0;
      goodCnt = 0;
      repeat (3) tick();
   endtask

   task automatic fillPeriods(input int p, input int count);
      for (int k = 0; k < count; k++) stimPer.push_back(p);
   endtask

   // Scoreboard monitor: every transfer pops one expected result.
   always @(negedge clk) begin
      sb_entry_t e;
      if (reset && periodValid && periodReady) begin
         checkOutput("sb_nonempty", 32'(sbQ.size() != 0), 1);
         if (sbQ.size() != 0) begin
            e = sbQ.pop_front();
            checkOutput("sb_period", 32'(period), 32'(e.period));
            checkOutput("sb_sat", 32'(periodSat), 32'(e.sat));
            checkOutput("sb_lock", 32'(lock), 32'(e.lock));
            if (e.gap != 0) checkOutput("sb_gap", cycleCnt - lastXfer, e.gap);
         end
         lastXfer = cycleCnt;
      end
   end

   initial begin
      checks       = 0;
      errors       = 0;
      cycleCnt     = 0;
      lastXfer     = 0;
      goodCnt      = 0;
      reset        = 1'b0;
      en           = 1'b0;
      en2          = 1'b0;
      divIn        = 1'b0;
      periodReady  = 1'b1;
      periodReady2 = 1'b0;
      targetPeriod = 12'd8;
      lockTol      = 12'd1;

      repeat (3) tick();
      checkOutput("rst_period", 32'(period), 0);
      checkOutput("rst_valid", 32'(periodValid), 0);
      checkOutput("rst_sat", 32'(periodSat), 0);
      checkOutput("rst_overrun", 32'(overrun), 0);
      checkOutput("rst_lock", 32'(lock), 0);
      reset = 1'b1;
      repeat (2) tick();

      $display("[TB] steady divide by 5");
      stimPer.delete();
      fillPeriods(5, 12);
      fillPeriods(6, 1);
      applyStimulus(99);
      endRun();

      $display("[TB] averaging truncation 6,7,6,7");
      stimPer.delete();
      stimPer.push_back(6); stimPer.push_back(7);
      stimPer.push_back(6); stimPer.push_back(7);
      fillPeriods(6, 1);
      applyStimulus(99);
      endRun();

      $display("[TB] lock sequence 9,8,7,8,12");
      stimPer.delete();
      fillPeriods(9, 4);
      fillPeriods(8, 4);
      fillPeriods(7, 4);
      fillPeriods(8, 4);
      fillPeriods(12, 4);
      fillPeriods(6, 1);
      applyStimulus(99);
      endRun();

      $display("[TB] backpressure");
      periodReady = 1'b0;
      stimPer.delete();
      fillPeriods(5, 4);
      fillPeriods(7, 4);
      fillPeriods(6, 1);
      applyStimulus(1);
      checkOutput("bp_valid", 32'(periodValid), 1);
      checkOutput("bp_period", 32'(period), 5);
      checkOutput("bp_overrun", 32'(overrun), 1);
      periodReady = 1'b1;
      tick();
      periodReady = 1'b0;
      checkOutput("bp_valid_after", 32'(periodValid), 0);
      checkOutput("bp_overrun_after", 32'(overrun), 0);
      periodReady = 1'b1;
      endRun();

      $display("[TB] reset mid measurement");
      periodReady = 1'b0;
      stimPer.delete();
      fillPeriods(5, 4);
      fillPeriods(6, 1);
      applyStimulus(0);
      genPeriod(5);
      checkOutput("pre_rst_valid", 32'(periodValid), 1);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("arst_period", 32'(period), 0);
      checkOutput("arst_valid", 32'(periodValid), 0);
      checkOutput("arst_sat", 32'(periodSat), 0);
      checkOutput("arst_overrun", 32'(overrun), 0);
      checkOutput("arst_lock", 32'(lock), 0);
      tick();
      reset       = 1'b1;
      periodReady = 1'b1;
      goodCnt     = 0;
      repeat (3) tick();

      $display("[TB] enable toggle discards partial window");
      genPeriod(9);
      genPeriod(9);
      genPeriod(9);
      en = 1'b0;
      goodCnt = 0;
      repeat (2) tick();
      stimPer.delete();
      fillPeriods(5, 4);
      fillPeriods(6, 1);
      applyStimulus(99);
      endRun();

      $display("[TB] saturation on 4-bit counter");
      en2 = 1'b1;
      repeat (3) tick();
      for (int k = 0; k < 5; k++) genPeriod(40);
      for (int k = 0; k < 20 && !periodValid2; k++) tick();
      checkOutput("sat_valid", 32'(periodValid2), 1);
      checkOutput("sat_period", 32'(period2), 15);
      checkOutput("sat_flag", 32'(periodSat2), 1);
      checkOutput("sat_lock", 32'(lock2), 0);
      en2 = 1'b0;

      repeat (5) tick();
      checkOutput("sb_drain", sbQ.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
